// File: rtl/mipscpu_pkg.sv
// Shared definitions for the MIPS-style pipeline: operand select encodings,
// decoded-control field layout and the default datapath width.
package mipscpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CTRL_W     = 12;

  // Decoded control word layout: {alu_op[3:0], dst_addr[4:0], reg_write, mem_read, mem_write}
  localparam int CTRL_ALU_OP_LSB    = 8;
  localparam int CTRL_DST_LSB       = 3;
  localparam int CTRL_REG_WRITE_BIT = 2;
  localparam int CTRL_MEM_READ_BIT  = 1;
  localparam int CTRL_MEM_WRITE_BIT = 0;

  typedef enum logic {
    LHS_RS = 1'b0,
    LHS_RT = 1'b1
  } lhs_sel_e;

  typedef enum logic [1:0] {
    RHS_RS    = 2'b00,
    RHS_RT    = 2'b01,
    RHS_SHAMT = 2'b10,
    RHS_IMM   = 2'b11
  } rhs_sel_e;

  typedef logic [CTRL_W-1:0] ctrl_t;

  function automatic logic [REG_ADDR_W-1:0] ctrl_dst(input ctrl_t c);
    return c[CTRL_DST_LSB +: REG_ADDR_W];
  endfunction

  function automatic logic ctrl_mem_read(input ctrl_t c);
    return c[CTRL_MEM_READ_BIT];
  endfunction

  function automatic logic ctrl_mem_write(input ctrl_t c);
    return c[CTRL_MEM_WRITE_BIT];
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Bypass selection for one register source: EX result beats MEM result beats
// the register file; register 0 is never bypassed.
module fwd_mux
  import mipscpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0]     rf_data,
  input  logic                  exm_reg_write,
  input  logic [REG_ADDR_W-1:0] exm_dst_addr,
  input  logic [DATA_W-1:0]     exm_result,
  input  logic                  mwb_reg_write,
  input  logic [REG_ADDR_W-1:0] mwb_dst_addr,
  input  logic [DATA_W-1:0]     mwb_result,
  output logic [DATA_W-1:0]     fwd_data
);

  logic src_nonzero;
  logic exm_hit;
  logic mwb_hit;

  assign src_nonzero = (src_addr != '0);
  assign exm_hit     = src_nonzero && exm_reg_write && (exm_dst_addr == src_addr);
  assign mwb_hit     = src_nonzero && mwb_reg_write && (mwb_dst_addr == src_addr);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    fwd_data = rf_data;
    if (exm_hit) begin
      fwd_data = exm_result;
    end else if (mwb_hit) begin
      fwd_data = mwb_result;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: forwards rs/rt, selects ALU operands, detects load-use
// hazards and holds the result in a valid/ready pipeline register.
module alu_operand_stage
  import mipscpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  w_clk,
  input  logic                  w_rst_n,
  input  logic                  w_id_valid,
  output logic                  w_id_ready,
  input  logic [REG_ADDR_W-1:0] w_rs_addr,
  input  logic [REG_ADDR_W-1:0] w_rt_addr,
  input  logic [DATA_W-1:0]     w_rs_data,
  input  logic [DATA_W-1:0]     w_rt_data,
  input  logic [15:0]           w_imm16,
  input  logic                  w_alu_lhs_ctrl,
  input  logic [1:0]            w_alu_rhs_ctrl,
  input  logic [CTRL_W-1:0]     w_id_ctrl,
  input  logic                  w_exm_reg_write,
  input  logic [REG_ADDR_W-1:0] w_exm_dst_addr,
  input  logic [DATA_W-1:0]     w_exm_result,
  input  logic                  w_mwb_reg_write,
  input  logic [REG_ADDR_W-1:0] w_mwb_dst_addr,
  input  logic [DATA_W-1:0]     w_mwb_result,
  input  logic                  w_flush,
  input  logic                  w_ex_ready,
  output logic                  w_ex_valid,
  output logic [DATA_W-1:0]     w_ex_lhs,
  output logic [DATA_W-1:0]     w_ex_rhs,
  output logic [DATA_W-1:0]     w_ex_store_data,
  output logic [CTRL_W-1:0]     w_ex_ctrl
);

  lhs_sel_e                lhs_sel;
  rhs_sel_e                rhs_sel;
  logic [DATA_W-1:0]       rs_fwd;
  logic [DATA_W-1:0]       rt_fwd;
  logic [DATA_W-1:0]       lhs_next;
  logic [DATA_W-1:0]       rhs_next;
  logic                    rs_used;
  logic                    rt_used;
  logic [REG_ADDR_W-1:0]   held_dst;
  logic                    hazard;
  logic                    load_en;
  logic                    accept;

  assign lhs_sel = lhs_sel_e'(w_alu_lhs_ctrl);
  assign rhs_sel = rhs_sel_e'(w_alu_rhs_ctrl);

  fwd_mux #(.DATA_W(DATA_W)) u_fwd_rs (
    .src_addr      (w_rs_addr),
    .rf_data       (w_rs_data),
    .exm_reg_write (w_exm_reg_write),
    .exm_dst_addr  (w_exm_dst_addr),
    .exm_result    (w_exm_result),
    .mwb_reg_write (w_mwb_reg_write),
    .mwb_dst_addr  (w_mwb_dst_addr),
    .mwb_result    (w_mwb_result),
    .fwd_data      (rs_fwd)
  );

  fwd_mux #(.DATA_W(DATA_W)) u_fwd_rt (
    .src_addr      (w_rt_addr),
    .rf_data       (w_rt_data),
    .exm_reg_write (w_exm_reg_write),
    .exm_dst_addr  (w_exm_dst_addr),
    .exm_result    (w_exm_result),
    .mwb_reg_write (w_mwb_reg_write),
    .mwb_dst_addr  (w_mwb_dst_addr),
    .mwb_result    (w_mwb_result),
    .fwd_data      (rt_fwd)
  );

  always_comb begin
    lhs_next = (lhs_sel == LHS_RT) ? rt_fwd : rs_fwd;
    rhs_next = rs_fwd;
    case (rhs_sel)
      RHS_RS:    rhs_next = rs_fwd;
      RHS_RT:    rhs_next = rt_fwd;
      RHS_SHAMT: rhs_next = {{(DATA_W-5){1'b0}}, w_imm16[10:6]};
      RHS_IMM:   rhs_next = {{(DATA_W-16){w_imm16[15]}}, w_imm16};
      default:   rhs_next = rs_fwd;
    endcase
  end

  // Stores read rt even when no ALU operand selects it.
  assign rs_used = (lhs_sel == LHS_RS) || (rhs_sel == RHS_RS);
  assign rt_used = (lhs_sel == LHS_RT) || (rhs_sel == RHS_RT) || ctrl_mem_write(w_id_ctrl);

  assign held_dst = ctrl_dst(w_ex_ctrl);
  assign hazard   = w_ex_valid && ctrl_mem_read(w_ex_ctrl) && (held_dst != '0) &&
                    ((rs_used && (held_dst == w_rs_addr)) ||
                     (rt_used && (held_dst == w_rt_addr)));

  assign load_en    = !w_ex_valid || w_ex_ready;
  assign w_id_ready = load_en && !hazard && !w_flush;
  assign accept     = w_id_valid && w_id_ready;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      w_ex_valid      <= 1'b0;
      w_ex_lhs        <= '0;
      w_ex_rhs        <= '0;
      w_ex_store_data <= '0;
      w_ex_ctrl       <= '0;
    end else if (w_flush) begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      w_ex_valid <= 1'b0;
    end else if (load_en) begin
      if (accept) begin
        w_ex_valid      <= 1'b1;
        w_ex_lhs        <= lhs_next;
        w_ex_rhs        <= rhs_next;
        w_ex_store_data <= rt_fwd;
        w_ex_ctrl       <= w_id_ctrl;
      end else begin
        // Bubble: data registers keep their old contents, only valid drops.
        w_ex_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed plus randomized check of alu_operand_stage against a cycle-level
// behavioural model of the operand stage.
module tb_alu_operand_stage;

  localparam int DATA_W = 32;

  logic              w_clk = 1'b0;
  logic              w_rst_n;
  logic              w_id_valid;
  logic              w_id_ready;
  logic [4:0]        w_rs_addr, w_rt_addr;
  logic [DATA_W-1:0] w_rs_data, w_rt_data;
  logic [15:0]       w_imm16;
  logic              w_alu_lhs_ctrl;
  logic [1:0]        w_alu_rhs_ctrl;
  logic [11:0]       w_id_ctrl;
  logic              w_exm_reg_write;
  logic [4:0]        w_exm_dst_addr;
  logic [DATA_W-1:0] w_exm_result;
  logic              w_mwb_reg_write;
  logic [4:0]        w_mwb_dst_addr;
  logic [DATA_W-1:0] w_mwb_result;
  logic              w_flush;
  logic              w_ex_ready;
  logic              w_ex_valid;
  logic [DATA_W-1:0] w_ex_lhs, w_ex_rhs, w_ex_store_data;
  logic [11:0]       w_ex_ctrl;

  alu_operand_stage #(.DATA_W(DATA_W)) dut (
    .w_clk           (w_clk),
    .w_rst_n         (w_rst_n),
    .w_id_valid      (w_id_valid),
    .w_id_ready      (w_id_ready),
    .w_rs_addr       (w_rs_addr),
    .w_rt_addr       (w_rt_addr),
    .w_rs_data       (w_rs_data),
    .w_rt_data       (w_rt_data),
    .w_imm16         (w_imm16),
    .w_alu_lhs_ctrl  (w_alu_lhs_ctrl),
    .w_alu_rhs_ctrl  (w_alu_rhs_ctrl),
    .w_id_ctrl       (w_id_ctrl),
    .w_exm_reg_write (w_exm_reg_write),
    .w_exm_dst_addr  (w_exm_dst_addr),
    .w_exm_result    (w_exm_result),
    .w_mwb_reg_write (w_mwb_reg_write),
    .w_mwb_dst_addr  (w_mwb_dst_addr),
    .w_mwb_result    (w_mwb_result),
    .w_flush         (w_flush),
    .w_ex_ready      (w_ex_ready),
    .w_ex_valid      (w_ex_valid),
    .w_ex_lhs        (w_ex_lhs),
    .w_ex_rhs        (w_ex_rhs),
    .w_ex_store_data (w_ex_store_data),
    .w_ex_ctrl       (w_ex_ctrl)
  );

  always #5 w_clk = ~w_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: contents of the ID/EX register as the rules describe them.
  logic              m_valid;
  logic [DATA_W-1:0] m_lhs, m_rhs, m_store;
  logic [11:0]       m_ctrl;

  task automatic model_reset();
    m_valid = 1'b0;
    m_lhs   = '0;
    m_rhs   = '0;
    m_store = '0;
    m_ctrl  = '0;
  endtask

  function automatic logic [DATA_W-1:0] fwd(input logic [4:0] a, input logic [DATA_W-1:0] rf);
    if (a == 5'd0) return rf;
    if (w_exm_reg_write && w_exm_dst_addr == a) return w_exm_result;
    if (w_mwb_reg_write && w_mwb_dst_addr == a) return w_mwb_result;
    return rf;
  endfunction

  function automatic logic model_ready();
    logic       rs_used, rt_used, hz;
    logic [4:0] dst;
    rs_used = (w_alu_lhs_ctrl == 1'b0) || (w_alu_rhs_ctrl == 2'b00);
    rt_used = (w_alu_lhs_ctrl == 1'b1) || (w_alu_rhs_ctrl == 2'b01) || w_id_ctrl[0];
    dst     = m_ctrl[7:3];
    hz      = m_valid && m_ctrl[1] && (dst != 5'd0) &&
              ((rs_used && dst == w_rs_addr) || (rt_used && dst == w_rt_addr));
    return (!m_valid || w_ex_ready) && !hz && !w_flush;
  endfunction

  task automatic model_edge(input logic rdy);
    logic [DATA_W-1:0] rs_f, rt_f, rhs;
    rs_f = fwd(w_rs_addr, w_rs_data);
    rt_f = fwd(w_rt_addr, w_rt_data);
    case (w_alu_rhs_ctrl)
      2'b00:   rhs = rs_f;
      2'b01:   rhs = rt_f;
      2'b10:   rhs = DATA_W'(w_imm16[10:6]);
      default: rhs = DATA_W'($signed(w_imm16));
    endcase
    if (w_flush) begin
      m_valid = 1'b0;
    end else if (!m_valid || w_ex_ready) begin
      if (w_id_valid && rdy) begin
        m_valid = 1'b1;
        m_lhs   = w_alu_lhs_ctrl ? rt_f : rs_f;
        m_rhs   = rhs;
        m_store = rt_f;
        m_ctrl  = w_id_ctrl;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 64'(w_ex_valid), 64'(m_valid));
    check({tag, ".lhs"},   64'(w_ex_lhs), 64'(m_lhs));
    check({tag, ".rhs"},   64'(w_ex_rhs), 64'(m_rhs));
    check({tag, ".store"}, 64'(w_ex_store_data), 64'(m_store));
    check({tag, ".ctrl"},  64'(w_ex_ctrl), 64'(m_ctrl));
  endtask

  // Called just after a falling edge with inputs applied; returns just after the next falling edge.
  task automatic cycle(input string tag);
    logic rdy;
    #1;
    rdy = model_ready();
    check({tag, ".ready"}, 64'(w_id_ready), 64'(rdy));
    model_edge(rdy);
    @(posedge w_clk);
    #1;
    check_outputs(tag);
    @(negedge w_clk);
  endtask

  task automatic idle();
    w_id_valid = 0; w_rs_addr = 0; w_rt_addr = 0; w_rs_data = 0; w_rt_data = 0;
    w_imm16 = 0; w_alu_lhs_ctrl = 0; w_alu_rhs_ctrl = 0; w_id_ctrl = 0;
    w_exm_reg_write = 0; w_exm_dst_addr = 0; w_exm_result = 0;
    w_mwb_reg_write = 0; w_mwb_dst_addr = 0; w_mwb_result = 0;
    w_flush = 0; w_ex_ready = 1;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [DATA_W-1:0] rsd,
                       input logic [4:0] rt, input logic [DATA_W-1:0] rtd,
                       input logic lhs, input logic [1:0] rhs, input logic [15:0] imm,
                       input logic [4:0] dst, input logic mr, input logic mw);
    w_id_valid = 1; w_rs_addr = rs; w_rs_data = rsd; w_rt_addr = rt; w_rt_data = rtd;
    w_alu_lhs_ctrl = lhs; w_alu_rhs_ctrl = rhs; w_imm16 = imm;
    w_id_ctrl = {4'h2, dst, 1'b1, mr, mw};
  endtask

  logic [DATA_W-1:0] save_lhs;
  logic [11:0]       save_ctrl;

  initial begin
    idle();
    w_rst_n = 0;
    model_reset();
    #2;
    check("rst.valid", 64'(w_ex_valid), 64'd0);
    check("rst.lhs", 64'(w_ex_lhs), 64'd0);
    check("rst.ready", 64'(w_id_ready), 64'd1);
    @(negedge w_clk);
    w_rst_n = 1;

    // add r3,r1,r2
    instr(5'd1, 32'd5, 5'd2, 32'd7, 1'b0, 2'b01, 16'h0, 5'd3, 1'b0, 1'b0);
    cycle("add");
    check("add.lhs_k", 64'(w_ex_lhs), 64'd5);
    check("add.rhs_k", 64'(w_ex_rhs), 64'd7);
    check("add.valid_k", 64'(w_ex_valid), 64'd1);

    // sll by shamt 4, then addi with imm -1
    instr(5'd0, 32'd0, 5'd2, 32'h3, 1'b1, 2'b10, 16'h0100, 5'd3, 1'b0, 1'b0);
    cycle("sll");
    check("sll.lhs_k", 64'(w_ex_lhs), 64'h3);
    check("sll.rhs_k", 64'(w_ex_rhs), 64'd4);
    instr(5'd1, 32'h10, 5'd0, 32'd0, 1'b0, 2'b11, 16'hFFFF, 5'd3, 1'b0, 1'b0);
    cycle("addi");
    check("addi.rhs_k", 64'(w_ex_rhs), 64'hFFFF_FFFF);

    // forwarding priority and register-0 exclusion
    instr(5'd4, 32'h11, 5'd0, 32'h22, 1'b0, 2'b01, 16'h0, 5'd3, 1'b0, 1'b0);
    w_exm_reg_write = 1; w_exm_dst_addr = 5'd4; w_exm_result = 32'hAA;
    w_mwb_reg_write = 1; w_mwb_dst_addr = 5'd4; w_mwb_result = 32'hBB;
    cycle("fwd_ex");
    check("fwd_ex.lhs_k", 64'(w_ex_lhs), 64'hAA);
    w_exm_dst_addr = 5'd7;
    cycle("fwd_mem");
    check("fwd_mem.lhs_k", 64'(w_ex_lhs), 64'hBB);
    w_rs_addr = 5'd0; w_rs_data = 32'h33; w_exm_dst_addr = 5'd0; w_mwb_dst_addr = 5'd0;
    cycle("fwd_r0");
    check("fwd_r0.lhs_k", 64'(w_ex_lhs), 64'h33);
    idle();

    // load-use: lw r5 then add r6,r5,r2
    instr(5'd1, 32'h100, 5'd0, 32'd0, 1'b0, 2'b11, 16'h4, 5'd5, 1'b1, 1'b0);
    cycle("lw");
    instr(5'd5, 32'h1, 5'd2, 32'h7, 1'b0, 2'b01, 16'h0, 5'd6, 1'b0, 1'b0);
    #1;
    check("lu.ready_k", 64'(w_id_ready), 64'd0);
    cycle("lu.stall");
    check("lu.bubble_k", 64'(w_ex_valid), 64'd0);
    w_mwb_reg_write = 1; w_mwb_dst_addr = 5'd5; w_mwb_result = 32'h55;
    cycle("lu.go");
    check("lu.lhs_k", 64'(w_ex_lhs), 64'h55);
    check("lu.valid_k", 64'(w_ex_valid), 64'd1);
    idle();

    // back-pressure for 3 cycles, then flush
    instr(5'd1, 32'h77, 5'd2, 32'h88, 1'b0, 2'b01, 16'h0, 5'd9, 1'b0, 1'b0);
    cycle("bp.load");
    save_lhs = w_ex_lhs; save_ctrl = w_ex_ctrl;
    instr(5'd3, 32'h99, 5'd4, 32'h66, 1'b0, 2'b01, 16'h0, 5'd10, 1'b0, 1'b0);
    w_ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp.ready_k", 64'(w_id_ready), 64'd0);
      cycle("bp.hold");
      check("bp.lhs_k", 64'(w_ex_lhs), 64'(save_lhs));
      check("bp.ctrl_k", 64'(w_ex_ctrl), 64'(save_ctrl));
    end
    w_flush = 1;
    cycle("flush");
    check("flush.valid_k", 64'(w_ex_valid), 64'd0);
    w_flush = 0; w_ex_ready = 1;
    cycle("refill");
    w_ex_ready = 0;
    cycle("stall2");
    #2;
    w_rst_n = 0;
    model_reset();
    #1;
    check("rst2.valid", 64'(w_ex_valid), 64'd0);
    check("rst2.lhs", 64'(w_ex_lhs), 64'd0);
    check("rst2.ctrl", 64'(w_ex_ctrl), 64'd0);
    @(negedge w_clk);
    w_rst_n = 1;
    idle();

    // randomized traffic with a small register pool to provoke matches
    for (int n = 0; n < 400; n++) begin
      w_id_valid      = ($urandom_range(0, 4) != 0);
      w_rs_addr       = 5'($urandom_range(0, 5));
      w_rt_addr       = 5'($urandom_range(0, 5));
      w_rs_data       = $urandom;
      w_rt_data       = $urandom;
      w_imm16         = 16'($urandom);
      w_alu_lhs_ctrl  = 1'($urandom);
      w_alu_rhs_ctrl  = 2'($urandom);
      w_id_ctrl       = {4'($urandom), 5'($urandom_range(0, 5)), 1'($urandom), 1'($urandom), 1'($urandom)};
      w_exm_reg_write = 1'($urandom);
      w_exm_dst_addr  = 5'($urandom_range(0, 5));
      w_exm_result    = $urandom;
      w_mwb_reg_write = 1'($urandom);
      w_mwb_dst_addr  = 5'($urandom_range(0, 5));
      w_mwb_result    = $urandom;
      w_flush         = ($urandom_range(0, 9) == 0);
      w_ex_ready      = ($urandom_range(0, 3) != 0);
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
